// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per clock.
// Optional macro MULTDIV_ZERO_BYPASS_EN finishes zero-operand operations in one clock.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divby0
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_op, r_hi, r_lo;
    logic             r_is_div, r_neg_res, r_neg_rem, r_done, r_divby0;

    logic             w_go_mult, w_go_div, w_div0, w_bypass, w_last;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [WIDTH:0]   w_sum, w_rem_sh, w_diff;
    logic             w_qbit;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

    // start_mult has priority when both requests arrive together
    assign w_go_mult = (r_state == IDLE) && start_mult;
    assign w_go_div  = (r_state == IDLE) && !start_mult && start_div && (b != '0);
    assign w_div0    = (r_state == IDLE) && !start_mult && start_div && (b == '0);

`ifdef MULTDIV_ZERO_BYPASS_EN
    assign w_bypass = (w_go_mult && ((a == '0) || (b == '0))) || (w_go_div && (a == '0));
`else
    assign w_bypass = 1'b0;
`endif

    assign w_abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    // Multiply step: multiplier sits in acc_lo and shifts out as product bits shift in
    assign w_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_op} : '0);

    // Divide step: partial remainder never exceeds the divisor, so bit WIDTH of w_diff is the borrow
    assign w_rem_sh = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_op};
    assign w_qbit   = !w_diff[WIDTH];

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_res ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix  = r_neg_res ? (~r_acc_lo + 1'b1) : r_acc_lo;
    assign w_rem_fix  = r_neg_rem ? (~r_acc_hi + 1'b1) : r_acc_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_bypass)       w_next = FINISH;
                else if (w_go_mult) w_next = MULT;
                else if (w_go_div)  w_next = DIV;
            end
            MULT, DIV: if (w_last) w_next = FINISH;
            FINISH:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_op      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_done    <= 1'b0;
            r_divby0  <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_divby0 <= w_div0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_bypass) begin
                        r_acc_hi  <= '0;
                        r_acc_lo  <= '0;
                        r_is_div  <= 1'b0;
                        r_neg_res <= 1'b0;
                        r_neg_rem <= 1'b0;
                    end else if (w_go_mult) begin
                        r_acc_hi  <= '0;
                        r_acc_lo  <= w_abs_b;
                        r_op      <= w_abs_a;
                        r_is_div  <= 1'b0;
                        r_neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_rem <= 1'b0;
                    end else if (w_go_div) begin
                        r_acc_hi  <= '0;
                        r_acc_lo  <= w_abs_a;
                        r_op      <= w_abs_b;
                        r_is_div  <= 1'b1;
                        r_neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_rem <= a[WIDTH-1];
                    end
                end
                MULT: begin
                    r_acc_hi <= w_sum[WIDTH:1];
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
                end
                DIV: begin
                    r_acc_hi <= w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_qbit};
                    r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
                end
                FINISH: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign hi     = r_hi;
    assign lo     = r_lo;
    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign divby0 = r_divby0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: signed results, latency, busy/done/divby0 timing,
// start arbitration, and mid-operation reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, divby0;

    int n_chk = 0;
    int n_err = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .divby0(divby0)
    );

    always #5 clk = ~clk;

`ifdef MULTDIV_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request, then counts edges after the start edge until done (bound 40).
    // A second start_mult is raised so that it is sampled on edge E+glitch (0 disables).
    task automatic run_op(input string tag, input logic sm, input logic sd,
                          input logic [31:0] av, input logic [31:0] bv, input int glitch,
                          output int lat, output logic busy32);
        lat    = 0;
        busy32 = 1'b0;
        @(negedge clk);
        a = av; b = bv; start_mult = sm; start_div = sd;
        @(posedge clk); #1;
        start_mult = 1'b0; start_div = 1'b0;
        check({tag, " busy after start"}, 64'(busy), 64'd1);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 32) busy32 = busy;
            if (glitch != 0 && i == glitch - 1) begin
                start_mult = 1'b1; a = 32'd5; b = 32'd5;
            end
            if (glitch != 0 && i == glitch) start_mult = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat != 0) begin
            check({tag, " busy at done"}, 64'(busy), 64'd0);
            @(posedge clk); #1;
            check({tag, " done one cycle"}, 64'(done), 64'd0);
        end
    endtask

    int   lat;
    logic b32;
    int   seen;

    initial begin
        reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
        #12;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset flags", {61'd0, busy, done, divby0}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, lat, b32);
        check("mul 7*-3 latency", 64'(lat), 64'd33);
        check("mul 7*-3 busy E+32", 64'(b32), 64'd1);
        check("mul 7*-3 result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op("mul min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, lat, b32);
        check("mul min*min result", {hi, lo}, 64'h4000_0000_0000_0000);

        run_op("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, b32);
        check("div -7/2 latency", 64'(lat), 64'd33);
        check("div -7/2 result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("div 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 0, lat, b32);
        check("div 100/7 result", {hi, lo}, {32'd2, 32'd14});

        run_op("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, b32);
        check("div min/-1 result", {hi, lo}, {32'd0, 32'h8000_0000});

        // Divide by zero: one-cycle divby0, no busy, no done, hi/lo hold
        @(negedge clk);
        a = 32'd5; b = 32'd0; start_div = 1'b1;
        @(posedge clk); #1;
        start_div = 1'b0;
        check("div0 pulse", 64'(divby0), 64'd1);
        check("div0 busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 0) check("div0 pulse width", 64'(divby0), 64'd0);
            if (done || busy) seen++;
        end
        check("div0 no done/busy", 64'(seen), 64'd0);
        check("div0 hold", {hi, lo}, {32'd0, 32'h8000_0000});

        run_op("mul glitch", 1'b1, 1'b0, 32'd6, 32'd7, 10, lat, b32);
        check("mul glitch latency", 64'(lat), 64'd33);
        check("mul glitch result", {hi, lo}, 64'd42);
        check("no requeued op", 64'(busy), 64'd0);

        run_op("both starts", 1'b1, 1'b1, 32'd3, 32'd4, 0, lat, b32);
        check("both starts latency", 64'(lat), 64'd33);
        check("both starts result", {hi, lo}, 64'd12);

        run_op("mul 0*9", 1'b1, 1'b0, 32'd0, 32'd9, 0, lat, b32);
        check("mul 0*9 latency", 64'(lat), 64'(ZERO_LAT));
        check("mul 0*9 result", {hi, lo}, 64'd0);

        run_op("mul 5*6", 1'b1, 1'b0, 32'd5, 32'd6, 0, lat, b32);
        check("mul 5*6 result", {hi, lo}, 64'd30);

        // Reset at E+5 of a multiply aborts it
        @(negedge clk);
        a = 32'd7; b = 32'hFFFF_FFFD; start_mult = 1'b1;
        @(posedge clk); #1;
        start_mult = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort hi/lo", {hi, lo}, 64'd0);
        check("abort flags", {61'd0, busy, done, divby0}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("abort no done", 64'(seen), 64'd0);

        run_op("recover 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 0, lat, b32);
        check("recover result", {hi, lo}, {32'd2, 32'd14});

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
